mem_dump_engine: RTL and testbench

- Readback path for the instruction/data RAMs behind mem_controller: on command, reads a contiguous range of 32-bit words through a synchronous RAM read port and streams them out as bytes on a valid/ready byte stream.
- Memory image loading writes RAM contents in; this block reads them back out for self-checking benches, debug UART, or scan-out of program results.
- Single clock domain, sits beside mem_controller on a dedicated read port.

---
 rtl/mem_dump_engine_pkg.sv | 14 +
 rtl/mem_dump_engine_if.sv | 29 ++
 rtl/mem_dump_engine_serializer.sv | 48 ++++
 rtl/mem_dump_engine.sv | 83 ++++++++
 tb/tb_mem_dump_engine.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/mem_dump_engine_pkg.sv
// Shared constants for the RAM readback engine: FSM encoding and word geometry.
package mem_dump_engine_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_READ    = 3'd1;
  localparam logic [2:0] ST_CAPTURE = 3'd2;
  localparam logic [2:0] ST_SEND    = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  localparam int         BYTES_PER_WORD = 4;
  localparam int         WORD_BITS      = BYTES_PER_WORD * 8;
  localparam logic [1:0] LAST_BYTE_IDX  = 2'(BYTES_PER_WORD - 1);

endpackage

// File: rtl/mem_dump_engine_if.sv
// Command, RAM read port and byte stream of the dump engine bundled together.
interface mem_dump_engine_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [ADDR_WIDTH:0]   word_count;
  logic                  busy;
  logic                  done;
  logic                  mem_re;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  out_valid;
  logic [7:0]            out_data;
  logic                  out_last;
  logic                  out_ready;

  // master is the engine itself; slave is the controller/RAM/sink side
  modport master (
    input  start, base_addr, word_count, mem_rdata, out_ready,
    output busy, done, mem_re, mem_addr, out_valid, out_data, out_last
  );

  modport slave (
    output start, base_addr, word_count, mem_rdata, out_ready,
    input  busy, done, mem_re, mem_addr, out_valid, out_data, out_last
  );
endinterface

// File: rtl/mem_dump_engine_serializer.sv
// Word-to-byte serializer: holds one captured word and presents it LSB byte first.
module mem_dump_serializer
  import mem_dump_engine_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [WORD_BITS-1:0] word,
  input  logic                 final_word,
  input  logic                 ready,
  output logic                 valid,
  output logic [7:0]           data,
  output logic                 last,
  output logic                 word_done
);

  logic [WORD_BITS-1:0] shift_reg;
  logic [1:0]           idx_reg;
  logic                 valid_reg;
  logic                 accept;

  assign accept    = valid_reg && ready;
  assign word_done = accept && (idx_reg == LAST_BYTE_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg <= '0;
      idx_reg   <= '0;
      valid_reg <= 1'b0;
    end else if (load) begin
      shift_reg <= word;
      idx_reg   <= '0;
      valid_reg <= 1'b1;
    end else if (accept) begin
      shift_reg <= {8'h00, shift_reg[WORD_BITS-1:8]};
      idx_reg   <= idx_reg + 2'd1;
      if (idx_reg == LAST_BYTE_IDX) begin
        valid_reg <= 1'b0;
      end
    end
  end

  // Outputs come straight from registers, so a stalled byte stays put
  assign valid = valid_reg;
  assign data  = shift_reg[7:0];
  assign last  = (idx_reg == LAST_BYTE_IDX) && final_word;

endmodule

// File: rtl/mem_dump_engine.sv
// Reads a contiguous run of RAM words and streams them out as little-endian bytes.
module mem_dump_engine
  import mem_dump_engine_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  mem_dump_engine_if.master  bus
);

  localparam logic [ADDR_WIDTH:0] REM_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [2:0]            state_reg;
  logic [2:0]            state_next;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [ADDR_WIDTH:0]   remaining_reg;
  logic [DATA_WIDTH-1:0] rdata_word;
  logic                  word_done;
  logic                  more_words;

  assign rdata_word = bus.mem_rdata;
  assign more_words = remaining_reg > REM_ONE;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (bus.start) begin
          state_next = (bus.word_count == '0) ? ST_DONE : ST_READ;
        end
      end
      ST_READ:    state_next = ST_CAPTURE;
      ST_CAPTURE: state_next = ST_SEND;
      ST_SEND: begin
        if (word_done) begin
          state_next = more_words ? ST_READ : ST_DONE;
        end
      end
      ST_DONE:    state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      addr_reg      <= '0;
      remaining_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == ST_IDLE && bus.start) begin
        addr_reg      <= bus.base_addr;
        remaining_reg <= bus.word_count;
      end else if (state_reg == ST_SEND && word_done && more_words) begin
        // address wraps naturally at the RAM size
        addr_reg      <= addr_reg + ADDR_WIDTH'(1);
        remaining_reg <= remaining_reg - REM_ONE;
      end
    end
  end

  mem_dump_serializer u_serializer (
    .clk        (clk),
    .rst        (rst),
    .load       (state_reg == ST_CAPTURE),
    .word       (rdata_word),
    .final_word (remaining_reg == REM_ONE),
    .ready      (bus.out_ready),
    .valid      (bus.out_valid),
    .data       (bus.out_data),
    .last       (bus.out_last),
    .word_done  (word_done)
  );

  assign bus.busy     = (state_reg == ST_READ) || (state_reg == ST_CAPTURE) ||
                        (state_reg == ST_SEND);
  assign bus.done     = (state_reg == ST_DONE);
  assign bus.mem_re   = (state_reg == ST_READ);
  assign bus.mem_addr = addr_reg;

endmodule

// File: tb/tb_mem_dump_engine.sv
// Directed bench for mem_dump_engine: vector table of dumps plus reset-abort sequence.
module tb_mem_dump_engine;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_dump_engine_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) bus ();

  mem_dump_engine #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] ram [1024];
  always @(posedge clk) if (bus.mem_re) bus.mem_rdata <= ram[bus.mem_addr];

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [9:0]  base;
    logic [10:0] count;
    logic [6:0]  pat;
    int          plen;
    bit          glitch;
    int          exp_nbytes;
    logic [7:0]  exp_first;
    logic [7:0]  exp_last;
    int          exp_done_cyc;
  } vec_t;

  vec_t vecs [5];

  logic [7:0]  byte_q [$];
  logic        last_q [$];
  logic [9:0]  addr_q [$];
  int          done_cnt;
  int          done_cyc;
  int          first_valid;

  task automatic run_dump(input logic [9:0] base, input logic [10:0] cnt,
                          input logic [6:0] pat, input int plen, input bit glitch);
    logic pv, pr, pl;
    logic [7:0] pd;
    byte_q.delete(); last_q.delete(); addr_q.delete();
    done_cnt = 0; done_cyc = -1; first_valid = -1;
    pv = 0; pr = 0; pl = 0; pd = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.base_addr = base; bus.word_count = cnt; bus.out_ready = 1'b1;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (c == 1) begin
        bus.base_addr = base + 10'h155;
        bus.word_count = 11'd7;
      end
      if (glitch && c == 4) begin
        bus.start = 1'b1;
        bus.base_addr = base + 10'h100;
        bus.word_count = 11'd5;
      end
      bus.out_ready = (c < 3) ? 1'b1 : pat[(c - 3) % plen];
      if (pv && !pr) begin
        check("stall_valid_held", 32'(bus.out_valid), 32'd1);
        check("stall_data_held", 32'(bus.out_data), 32'(pd));
        check("stall_last_held", 32'(bus.out_last), 32'(pl));
      end
      if (bus.out_valid && first_valid < 0) first_valid = c;
      if (bus.out_valid && bus.out_ready) begin
        byte_q.push_back(bus.out_data);
        last_q.push_back(bus.out_last);
      end
      if (bus.mem_re) addr_q.push_back(bus.mem_addr);
      if (bus.done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      pv = bus.out_valid; pr = bus.out_ready; pd = bus.out_data; pl = bus.out_last;
      if (done_cyc >= 0 && c >= done_cyc + 2) break;
    end
    bus.out_ready = 1'b1;
  endtask

  task automatic check_dump(input vec_t v, input int id);
    int nlast;
    logic [31:0] w;
    logic [9:0]  a;
    check($sformatf("v%0d_nbytes", id), 32'(byte_q.size()), 32'(v.exp_nbytes));
    check($sformatf("v%0d_nreads", id), 32'(addr_q.size()), 32'(v.count));
    check($sformatf("v%0d_done_cnt", id), 32'(done_cnt), 32'd1);
    check($sformatf("v%0d_done_cyc", id), 32'(done_cyc), 32'(v.exp_done_cyc));
    check($sformatf("v%0d_first_valid", id), 32'(first_valid),
          (v.count == 0) ? 32'hFFFF_FFFF : 32'd3);
    check($sformatf("v%0d_busy_after", id), 32'(bus.busy), 32'd0);
    for (int i = 0; i < addr_q.size(); i++) begin
      a = v.base + 10'(i);
      check($sformatf("v%0d_addr%0d", id, i), 32'(addr_q[i]), 32'(a));
    end
    nlast = 0;
    for (int i = 0; i < byte_q.size(); i++) begin
      a = v.base + 10'(i / 4);
      w = ram[a] >> (8 * (i % 4));
      check($sformatf("v%0d_byte%0d", id, i), 32'(byte_q[i]), 32'(w[7:0]));
      if (last_q[i]) nlast++;
    end
    check($sformatf("v%0d_nlast", id), 32'(nlast), (v.count == 0) ? 32'd0 : 32'd1);
    if (byte_q.size() > 0 && v.exp_nbytes > 0) begin
      check($sformatf("v%0d_first_byte", id), 32'(byte_q[0]), 32'(v.exp_first));
      check($sformatf("v%0d_last_byte", id), 32'(byte_q[byte_q.size()-1]), 32'(v.exp_last));
      check($sformatf("v%0d_last_flag", id), 32'(last_q[last_q.size()-1]), 32'd1);
    end
    $display("[TB] dump %0d base=0x%03h count=%0d bytes=%0d reads=%0d done_cyc=%0d",
             id, v.base, v.count, byte_q.size(), addr_q.size(), done_cyc);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 32'h0;
    ram[10'h010] = 32'h11223344;
    ram[10'h011] = 32'h55667788;
    ram[10'h012] = 32'h99AABBCC;
    ram[10'h013] = 32'hDDEEFF00;
    ram[10'h3FE] = 32'hA0A1A2A3;
    ram[10'h3FF] = 32'hB0B1B2B3;
    ram[10'h000] = 32'hC0C1C2C3;
    ram[10'h050] = 32'hDEADBEEF;
    ram[10'h051] = 32'h01234567;
    ram[10'h020] = 32'h5A6B7C8D;

    //          base     count  pat         plen glitch nbytes first  last   done
    vecs[0] = '{10'h010, 11'd1, 7'b1111111, 1,   1'b0,  4,     8'h44, 8'h11, 7};
    vecs[1] = '{10'h3FE, 11'd3, 7'b1111111, 1,   1'b0,  12,    8'hA3, 8'hC0, 19};
    // ready sequence 1,0,0,1,0,1,1 from the first valid beat (bit 0 first)
    vecs[2] = '{10'h010, 11'd1, 7'b1101001, 7,   1'b0,  4,     8'h44, 8'h11, 10};
    vecs[3] = '{10'h123, 11'd0, 7'b1111111, 1,   1'b0,  0,     8'h00, 8'h00, 1};
    vecs[4] = '{10'h050, 11'd2, 7'b1111111, 1,   1'b1,  8,     8'hEF, 8'h01, 13};

    bus.start = 0; bus.base_addr = 0; bus.word_count = 0; bus.out_ready = 1;
    @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_mem_re", 32'(bus.mem_re), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_last", 32'(bus.out_last), 32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 5; k++) begin
      run_dump(vecs[k].base, vecs[k].count, vecs[k].pat, vecs[k].plen, vecs[k].glitch);
      check_dump(vecs[k], k);
    end

    // Abort a 4-word dump while byte 2 of word 1 is stalled
    @(negedge clk);
    bus.start = 1'b1; bus.base_addr = 10'h010; bus.word_count = 11'd4; bus.out_ready = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (c == 11) bus.out_ready = 1'b0;
    end
    check("abort_pending_valid", 32'(bus.out_valid), 32'd1);
    check("abort_pending_byte", 32'(bus.out_data), 32'h66);
    rst = 1'b1;
    #1;
    check("abort_valid_drop", 32'(bus.out_valid), 32'd0);
    check("abort_busy_drop", 32'(bus.busy), 32'd0);
    check("abort_mem_re_drop", 32'(bus.mem_re), 32'd0);
    check("abort_done_drop", 32'(bus.done), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("abort_no_done", 32'(bus.done), 32'd0);
    end
    rst = 1'b0;
    bus.out_ready = 1'b1;
    $display("[TB] abort of 4-word dump at word 1 byte 2");
    begin
      vec_t v;
      v = '{10'h020, 11'd1, 7'b1111111, 1, 1'b0, 4, 8'h8D, 8'h5A, 7};
      run_dump(v.base, v.count, v.pat, v.plen, v.glitch);
      check_dump(v, 5);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
